// File: rtl/request_unit.sv
// Instruction/data memory request sequencer between the cache interface and the control unit.
// Optional memory-wait counter on stall_cnt is built only when REQUEST_UNIT_PERF_EN is defined.
module request_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dren_req,
  input  logic        dwen_req,
  input  logic        halt_req,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        halt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        store_q;
  logic        store_next;
  logic [31:0] instr_q;
  logic [31:0] instr_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      store_q <= 1'b0;
      instr_q <= 32'h0;
    end else begin
      state   <= state_next;
      store_q <= store_next;
      instr_q <= instr_next;
    end
  end

  // Store wins over load when both decodes are set; halt wins over both.
  always_comb begin
    state_next = state;
    store_next = store_q;
    instr_next = instr_q;
    pc_en      = 1'b0;
    case (state)
      FETCH: begin
        if (ihit) begin
          if (halt_req) begin
            state_next = HALTED;
          end else if (dwen_req || dren_req) begin
            state_next = DATA;
            store_next = dwen_req;
            instr_next = imemload;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Requests decode from registered state only, so they move on CLK or RST alone.
  assign imemREN = (state == FETCH);
  assign dmemREN = (state == DATA) && !store_q;
  assign dmemWEN = (state == DATA) && store_q;
  assign halt    = (state == HALTED);

  assign instr  = (state == DATA) ? instr_q : imemload;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

`ifdef REQUEST_UNIT_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        stall_cyc;
  logic [31:0] stall_q;

  assign stall_cyc = ((state == FETCH) && !ihit) || ((state == DATA) && !dhit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= 32'h0;
    end else if (stall_cyc) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Scoreboarded random/directed bench for request_unit; expected outputs come from a
// transaction-level model of fetch, data access and halt behaviour.
module tb_request_unit;

`ifdef REQUEST_UNIT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] imemload;
  logic        ihit, dhit, dren_req, dwen_req, halt_req;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
  logic [31:0] instr, stall_cnt;
  logic [5:0]  opcode, funct;

  request_unit dut (
    .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
    .dren_req(dren_req), .dwen_req(dwen_req), .halt_req(halt_req),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc_en(pc_en),
    .instr(instr), .opcode(opcode), .funct(funct), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        pc_en;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  // Model: what memory access (if any) is in flight, and which word it belongs to.
  int          busy;        // 0 none, 1 load, 2 store
  bit          halted;
  int          halted_cycles;
  logic [31:0] held;
  logic [31:0] waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    busy = 0;
    halted = 1'b0;
    halted_cycles = 0;
    held = 32'h0;
    waits = 32'h0;
  endtask

  // Async reset asserted away from any clock edge; outputs must react at once.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_imemREN", 32'(imemREN), 32'h1);
    chk("rst_dmemREN", 32'(dmemREN), 32'h0);
    chk("rst_dmemWEN", 32'(dmemWEN), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [31:0] ld, input bit ih, input bit dh,
                      input bit dr, input bit dw, input bit hr);
    exp_t e;
    imemload = ld; ihit = ih; dhit = dh; dren_req = dr; dwen_req = dw; halt_req = hr;
    e.imemREN = !halted && (busy == 0);
    e.dmemREN = (busy == 1);
    e.dmemWEN = (busy == 2);
    e.halt    = halted;
    e.instr   = (busy != 0) ? held : ld;
    e.pc_en   = !halted && (((busy == 0) && ih && !hr && !dr && !dw) || ((busy != 0) && dh));
    e.stall   = PERF ? waits : 32'h0;
    q.push_back(e);
    if (halted) begin
      halted_cycles++;
    end else if (busy != 0) begin
      if (dh) busy = 0;
      else if (waits != 32'hFFFF_FFFF) waits = waits + 32'd1;
    end else if (!ih) begin
      if (waits != 32'hFFFF_FFFF) waits = waits + 32'd1;
    end else if (hr) begin
      halted = 1'b1;
    end else if (dw) begin
      busy = 2; held = ld;
    end else if (dr) begin
      busy = 1; held = ld;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imemREN", 32'(imemREN), 32'(e.imemREN));
        chk("dmemREN", 32'(dmemREN), 32'(e.dmemREN));
        chk("dmemWEN", 32'(dmemWEN), 32'(e.dmemWEN));
        chk("pc_en", 32'(pc_en), 32'(e.pc_en));
        chk("halt", 32'(halt), 32'(e.halt));
        chk("instr", instr, e.instr);
        chk("opcode", 32'(opcode), 32'(e.instr[31:26]));
        chk("funct", 32'(funct), 32'(e.instr[5:0]));
        chk("stall_cnt", stall_cnt, e.stall);
      end
    end
  end

  initial begin : stim
    RST = 1'b0; imemload = 32'h0; ihit = 1'b0; dhit = 1'b0;
    dren_req = 1'b0; dwen_req = 1'b0; halt_req = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // ALU stream: one instruction retired per cycle.
    for (int i = 0; i < 6; i++) step(32'h0022_1820, 1, 0, 0, 0, 0);

    // Load with two wait cycles; imemload and ihit wander while the word is held.
    step(32'h8C22_0004, 1, 0, 1, 0, 0);
    step($urandom, 1, 0, 0, 0, 0);
    step($urandom, 0, 0, 0, 0, 0);
    step($urandom, 1, 1, 0, 0, 0);
    step(32'h0022_1820, 1, 0, 0, 0, 0);

    // Load and store decoded together: store only.
    step(32'hAC22_0008, 1, 0, 1, 1, 0);
    step($urandom, 1, 0, 1, 0, 0);
    step($urandom, 1, 1, 1, 0, 0);
    step(32'h0022_1820, 1, 0, 0, 0, 0);

    // Halt beats a simultaneous store decode; later hits are ignored.
    step(32'hFFFF_FFFF, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step($urandom, 1, 1, 1, 1, 0);
    do_reset();

    // Reset while a store is outstanding.
    step(32'hAC00_0010, 1, 0, 0, 1, 0);
    step($urandom, 0, 0, 0, 0, 0);
    chk("pre_rst_dmemWEN", 32'(dmemWEN), 32'h1);
    do_reset();
    step(32'h0022_1820, 1, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      if (halted && halted_cycles > 3) begin
        do_reset();
      end else begin
        step($urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
             $urandom_range(0, 49) == 0);
      end
    end

    @(negedge CLK);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
